// File: rtl/control_unit_pkg.sv
// Shared opcode, ALU-op and control-bundle constants for the RV32I main decoder.
package control_unit_pkg;

   // RV32I major opcodes (instruction[6:0]) handled by this datapath
   localparam logic [6:0] R_type = 7'b0110011;
   localparam logic [6:0] I_type = 7'b0010011;
   localparam logic [6:0] L_type = 7'b0000011;
   localparam logic [6:0] S_type = 7'b0100011;
   localparam logic [6:0] B_type = 7'b1100011;

   // ALU-control class handed to the downstream ALU-control block
   localparam logic [1:0] ALUOP_ADD = 2'b00;  // address generation
   localparam logic [1:0] ALUOP_BR  = 2'b01;  // subtract/compare for branches
   localparam logic [1:0] ALUOP_R   = 2'b10;  // funct3/funct7 decoded downstream
   localparam logic [1:0] ALUOP_I   = 2'b11;  // funct3 decoded, funct7 only for shifts

   // Bundle layout, MSB first: {aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp}
   typedef struct packed {
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   // Don't-care fields (memToReg for stores/branches) are tied to 0
   localparam logic [7:0] R_format   = {6'b001000, ALUOP_R};
   localparam logic [7:0] I_format   = {6'b101000, ALUOP_I};
   localparam logic [7:0] L_format   = {6'b111100, ALUOP_ADD};
   localparam logic [7:0] S_format   = {6'b100010, ALUOP_ADD};
   localparam logic [7:0] B_format   = {6'b000001, ALUOP_BR};
   localparam logic [7:0] NOP_format = 8'b0000_0000;

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode-to-control-bundle table with an illegal-opcode flag.
module control_decode
   import control_unit_pkg::*;
(
   input  logic [6:0] opcode,
   output ctrl_t      ctrl,
   output logic       illegal
);

   // Table lookup; anything unmatched (including X/Z) falls to the inert bundle
   always_comb begin
      ctrl    = ctrl_t'(NOP_format);
      illegal = 1'b1;
      case (opcode)
         R_type: begin ctrl = ctrl_t'(R_format); illegal = 1'b0; end
         I_type: begin ctrl = ctrl_t'(I_format); illegal = 1'b0; end
         L_type: begin ctrl = ctrl_t'(L_format); illegal = 1'b0; end
         S_type: begin ctrl = ctrl_t'(S_format); illegal = 1'b0; end
         B_type: begin ctrl = ctrl_t'(B_format); illegal = 1'b0; end
         default: begin
            ctrl    = ctrl_t'(NOP_format);
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// RV32I main decoder: combinational control strobes plus a sticky illegal-opcode flag.
// There is no valid/ready handshake: control is valid in the same cycle as the
// opcode, and only illegalSeen is clocked.
module control_unit
   import control_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] instruction,
   output logic       branch,
   output logic       memRead,
   output logic       memToReg,
   output logic       memWrite,
   output logic       aluSrc,
   output logic       regWrite,
   output logic [1:0] aluOp,
   output logic       illegalOp,
   output logic       illegalSeen
);

   ctrl_t ctrl;
   logic  illegal;

   control_decode u_decode (
      .opcode  (instruction),
      .ctrl    (ctrl),
      .illegal (illegal)
   );

   // Unpack the bundle; decode ignores clk and rst entirely
   assign aluSrc    = ctrl.alu_src;
   assign memToReg  = ctrl.mem_to_reg;
   assign regWrite  = ctrl.reg_write;
   assign memRead   = ctrl.mem_read;
   assign memWrite  = ctrl.mem_write;
   assign branch    = ctrl.branch;
   assign aluOp     = ctrl.alu_op;
   assign illegalOp = illegal;

   // Sticky record of any unsupported opcode since the last reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegalSeen <= 1'b0;
      end else if (illegal == 1'b1) begin
         illegalSeen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: driver pushes expected {bundle, illegalOp,
// illegalSeen} words, a monitor pops and compares when a sample is presented.
module tb_control_unit;

   logic       clk;
   logic       rst;
   logic [6:0] instruction;
   logic       branch, memRead, memToReg, memWrite, aluSrc, regWrite;
   logic [1:0] aluOp;
   logic       illegalOp, illegalSeen;

   logic [9:0] exp_q[$];
   string      name_q[$];
   int         checks_total;
   int         checks_passed;
   bit         seen_m;
   event       sample_ev;

   control_unit dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .branch      (branch),
      .memRead     (memRead),
      .memToReg    (memToReg),
      .memWrite    (memWrite),
      .aluSrc      (aluSrc),
      .regWrite    (regWrite),
      .aluOp       (aluOp),
      .illegalOp   (illegalOp),
      .illegalSeen (illegalSeen)
   );

   // Clock: posedges at 5, 15, 25 ... ns
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hand-written decode table for the five legal opcodes
   function automatic logic [7:0] exp_bundle(input logic [6:0] op, output bit legal);
      legal = 1'b1;
      case (op)
         7'b0110011: exp_bundle = 8'b00100010;
         7'b0010011: exp_bundle = 8'b10100011;
         7'b0000011: exp_bundle = 8'b11110000;
         7'b0100011: exp_bundle = 8'b10001000;
         7'b1100011: exp_bundle = 8'b00000101;
         default: begin
            exp_bundle = 8'b00000000;
            legal      = 1'b0;
         end
      endcase
   endfunction

   // Queue an expectation and present a sample to the monitor
   task automatic expect_now(input logic [7:0] bundle, input bit ill, input bit seen,
                             input string nm);
      exp_q.push_back({bundle, ill, seen});
      name_q.push_back(nm);
      -> sample_ev;
      #0;
   endtask

   // Drive an opcode just after the falling edge and check before the next rising edge
   task automatic apply(input logic [6:0] op, input string nm);
      logic [7:0] b;
      bit         legal;
      @(negedge clk);
      instruction = op;
      #2;
      b = exp_bundle(op, legal);
      expect_now(b, !legal, seen_m, nm);
      if (!legal && !rst) seen_m = 1'b1;   // upcoming rising edge captures it
   endtask

   // Monitor: pop one expectation per presented sample and compare
   initial begin
      logic [9:0] act;
      logic [9:0] exp;
      string      nm;
      forever begin
         @(sample_ev);
         act = {aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp,
                illegalOp, illegalSeen};
         if (exp_q.size() == 0) begin
            checks_total++;
            $display("FAIL monitor: sample with empty expected queue, got %b", act);
         end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            checks_total++;
            if (act === exp) checks_passed++;
            else $display("FAIL %s: got bundle=%b ill=%b seen=%b, expected bundle=%b ill=%b seen=%b",
                          nm, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
         end
      end
   end

   // Watchdog
   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      seen_m        = 1'b0;
      rst           = 1'b1;
      instruction   = 7'b0110011;
      #1;
      // Reset state: decode still live, sticky flag clear
      expect_now(8'b00100010, 1'b0, 1'b0, "reset_state_r_type");
      @(negedge clk);
      rst = 1'b0;

      // Legal opcodes
      apply(7'b0110011, "r_type");
      apply(7'b0010011, "i_type");
      apply(7'b0000011, "l_type");
      apply(7'b0100011, "s_type");
      apply(7'b1100011, "b_type");

      // Reset pulse, then an illegal opcode across one rising edge
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst         = 1'b0;
      seen_m      = 1'b0;
      instruction = 7'b1111111;
      #1;
      expect_now(8'b00000000, 1'b1, 1'b0, "illegal_before_edge");
      @(posedge clk);
      #1;
      expect_now(8'b00000000, 1'b1, 1'b1, "illegal_after_edge");
      seen_m = 1'b1;
      apply(7'b0110011, "seen_sticky_after_legal");
      apply(7'b0010011, "seen_sticky_second_edge");

      // Asynchronous reset mid-cycle, no rising edge in between
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      seen_m = 1'b0;
      expect_now(8'b10100011, 1'b0, 1'b0, "async_reset_clears_seen");
      instruction = 7'b0000011;
      #1;
      expect_now(8'b11110000, 1'b0, 1'b0, "decode_during_reset");
      instruction = 7'b0001111;
      @(posedge clk);
      #1;
      expect_now(8'b00000000, 1'b1, 1'b0, "reset_holds_seen_low");
      instruction = 7'b1100011;
      @(negedge clk);
      rst = 1'b0;

      // Instruction changes between edges: outputs follow immediately
      #2;
      instruction = 7'b0100011;
      #1;
      expect_now(8'b10001000, 1'b0, 1'b0, "mid_cycle_s_type");
      instruction = 7'b0110111;   // LUI: unsupported here
      #1;
      expect_now(8'b00000000, 1'b1, 1'b0, "mid_cycle_lui_illegal");
      instruction = 7'b1100011;
      #1;
      expect_now(8'b00000101, 1'b0, 1'b0, "mid_cycle_b_type");

      // Full opcode sweep
      for (int i = 0; i < 128; i++) begin
         apply(7'(i), $sformatf("sweep_op_%07b", 7'(i)));
      end

      #3;
      if (exp_q.size() != 0) begin
         checks_total++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
